// File: rtl/rupt_priority_ctrl.sv
// Priority rupt controller: captures request edges, grants the highest-priority
// pending source at an instruction boundary and handshakes the vector to the sequencer.
module rupt_priority_ctrl #(
  parameter int NSRC = 10,
  parameter int ADW  = 4
) (
  input  logic            CLOCK,
  input  logic            rst,
  input  logic            GOJAM,
  input  logic [NSRC-1:0] RUPTIN,
  input  logic            INHINT,
  input  logic            OVF,
  input  logic            EXTC,
  input  logic            INSTB,
  input  logic            RRPA,
  input  logic            RESUME,
  output logic            RUPTOR_,
  output logic [ADW-1:0]  RPTAD,
  output logic [NSRC-1:0] PEND,
  output logic            IIP
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t          state_q, state_d;
  logic [NSRC-1:0] pend_q, pend_d;
  logic [NSRC-1:0] prev_q;
  logic [NSRC-1:0] edge_w, clr_w;
  logic [ADW-1:0]  rptad_q, rptad_d;
  logic [ADW-1:0]  sel_w;
  logic            clear_sync;
  logic            grant_en;

  assign clear_sync = !rst || GOJAM;
  assign edge_w     = RUPTIN & ~prev_q;
  // Uses the registered pending set, so an edge in the strobe cycle waits for the next boundary.
  assign grant_en   = INSTB & ~INHINT & ~OVF & ~EXTC & ~IIP & (|pend_q);

  always_comb begin
    sel_w = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (pend_q[i]) sel_w = ADW'(i);
    end
  end

  always_ff @(posedge CLOCK) begin
    if (clear_sync) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_en) state_d = REQ;
      REQ:     if (RRPA)     state_d = SERVICE;
      SERVICE: if (RESUME)   state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  always_comb begin
    RUPTOR_ = (state_q != REQ);
    IIP     = (state_q == SERVICE);
  end

  // A new edge on the acknowledged source in the RRPA cycle keeps it pending.
  always_comb begin
    clr_w = '0;
    if (state_q == REQ && RRPA) begin
      for (int i = 0; i < NSRC; i++) begin
        if (ADW'(i + 1) == rptad_q) clr_w[i] = 1'b1;
      end
    end
    pend_d  = (pend_q & ~clr_w) | edge_w;
    rptad_d = rptad_q;
    if (state_q == IDLE)                 rptad_d = grant_en ? sel_w + 1'b1 : '0;
    else if (state_q == SERVICE && RESUME) rptad_d = '0;
  end

  always_ff @(posedge CLOCK) begin
    if (clear_sync) begin
      pend_q  <= '0;
      prev_q  <= '0;
      rptad_q <= '0;
    end else begin
      pend_q  <= pend_d;
      prev_q  <= RUPTIN;
      rptad_q <= rptad_d;
    end
  end

  assign PEND  = pend_q;
  assign RPTAD = rptad_q;

endmodule

// File: tb/tb_rupt_priority_ctrl.sv
// Bench for rupt_priority_ctrl: directed vector table, hand sequences for
// multi-cycle corners, then random stimulus against a cycle-level reference model.
module tb_rupt_priority_ctrl;
  localparam int NSRC = 10;
  localparam int ADW  = 4;

  logic            CLOCK = 1'b0;
  logic            rst, GOJAM, INHINT, OVF, EXTC, INSTB, RRPA, RESUME;
  logic [NSRC-1:0] RUPTIN;
  logic            RUPTOR_, IIP;
  logic [ADW-1:0]  RPTAD;
  logic [NSRC-1:0] PEND;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: pending set, last sample, granted source, handshake phase.
  logic [NSRC-1:0] m_pend, m_prev;
  int              m_src;
  bit              m_req, m_svc;

  typedef struct {
    logic            rst, gojam;
    logic [NSRC-1:0] ruptin;
    logic            instb, inhint, ovf, extc, rrpa, resume;
    logic            e_ruptor;
    logic [ADW-1:0]  e_rptad;
    logic [NSRC-1:0] e_pend;
    logic            e_iip;
  } vec_t;

  vec_t tbl[16];

  rupt_priority_ctrl #(.NSRC(NSRC), .ADW(ADW)) dut (
    .CLOCK  (CLOCK),
    .rst    (rst),
    .GOJAM  (GOJAM),
    .RUPTIN (RUPTIN),
    .INHINT (INHINT),
    .OVF    (OVF),
    .EXTC   (EXTC),
    .INSTB  (INSTB),
    .RRPA   (RRPA),
    .RESUME (RESUME),
    .RUPTOR_(RUPTOR_),
    .RPTAD  (RPTAD),
    .PEND   (PEND),
    .IIP    (IIP)
  );

  always #5 CLOCK = ~CLOCK;

  function automatic int lowest(logic [NSRC-1:0] p);
    for (int i = 0; i < NSRC; i++) if (p[i]) return i;
    return -1;
  endfunction

  task automatic model_step();
    logic [NSRC-1:0] edges, nxt;
    if (!rst || GOJAM) begin
      m_pend = '0; m_prev = '0; m_src = -1; m_req = 0; m_svc = 0;
    end else begin
      edges = RUPTIN & ~m_prev;
      nxt   = m_pend | edges;
      if (m_req) begin
        if (RRPA) begin
          if (!edges[m_src]) nxt[m_src] = 1'b0;
          m_req = 0; m_svc = 1;
        end
      end else if (m_svc) begin
        if (RESUME) begin m_svc = 0; m_src = -1; end
      end else if (INSTB && !INHINT && !OVF && !EXTC && m_pend != '0) begin
        m_src = lowest(m_pend);
        m_req = 1;
      end
      m_pend = nxt;
      m_prev = RUPTIN;
    end
  endtask

  task automatic step();
    @(posedge CLOCK);
    model_step();
    #1;
  endtask

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic chk_all(string tag, int e_ruptor, int e_rptad, int e_pend, int e_iip);
    chk({tag, ".RUPTOR_"}, int'(RUPTOR_), e_ruptor);
    chk({tag, ".RPTAD"},   int'(RPTAD),   e_rptad);
    chk({tag, ".PEND"},    int'(PEND),    e_pend);
    chk({tag, ".IIP"},     int'(IIP),     e_iip);
  endtask

  task automatic drive(logic r, logic gj, logic [NSRC-1:0] rin, logic ib, logic ih,
                       logic ov, logic ex, logic ra, logic rs);
    rst = r; GOJAM = gj; RUPTIN = rin; INSTB = ib; INHINT = ih;
    OVF = ov; EXTC = ex; RRPA = ra; RESUME = rs;
  endtask

  task automatic cyc(logic [NSRC-1:0] rin, logic ib, logic ra, logic rs);
    drive(1'b1, 1'b0, rin, ib, 1'b0, 1'b0, 1'b0, ra, rs);
    step();
  endtask

  initial begin
    m_pend = '0; m_prev = '0; m_src = -1; m_req = 0; m_svc = 0;
    drive(1'b0, 1'b0, '0, 0, 0, 0, 0, 0, 0);

    //          rst gj ruptin  ib ih ov ex ra rs | ruptor rptad pend   iip
    tbl[0]  = '{0, 0, 10'h000, 0, 0, 0, 0, 0, 0,  1, 4'd0, 10'h000, 0};
    tbl[1]  = '{1, 0, 10'h000, 0, 0, 0, 0, 0, 0,  1, 4'd0, 10'h000, 0};
    tbl[2]  = '{1, 0, 10'h008, 0, 0, 0, 0, 0, 0,  1, 4'd0, 10'h008, 0};
    tbl[3]  = '{1, 0, 10'h000, 1, 0, 0, 0, 0, 0,  0, 4'd4, 10'h008, 0};
    tbl[4]  = '{1, 0, 10'h000, 1, 1, 0, 0, 0, 1,  0, 4'd4, 10'h008, 0};
    tbl[5]  = '{1, 0, 10'h000, 0, 0, 0, 0, 1, 0,  1, 4'd4, 10'h000, 1};
    tbl[6]  = '{1, 0, 10'h000, 0, 0, 0, 0, 1, 0,  1, 4'd4, 10'h000, 1};
    tbl[7]  = '{1, 0, 10'h000, 0, 0, 0, 0, 0, 1,  1, 4'd0, 10'h000, 0};
    tbl[8]  = '{1, 0, 10'h000, 1, 0, 0, 0, 0, 0,  1, 4'd0, 10'h000, 0};
    tbl[9]  = '{1, 0, 10'h010, 0, 0, 0, 0, 0, 0,  1, 4'd0, 10'h010, 0};
    tbl[10] = '{1, 0, 10'h000, 1, 1, 0, 0, 0, 0,  1, 4'd0, 10'h010, 0};
    tbl[11] = '{1, 0, 10'h000, 1, 0, 1, 0, 0, 0,  1, 4'd0, 10'h010, 0};
    tbl[12] = '{1, 0, 10'h000, 1, 0, 0, 1, 0, 0,  1, 4'd0, 10'h010, 0};
    tbl[13] = '{1, 0, 10'h000, 1, 0, 0, 0, 0, 0,  0, 4'd5, 10'h010, 0};
    tbl[14] = '{1, 0, 10'h000, 0, 0, 0, 0, 1, 0,  1, 4'd5, 10'h000, 1};
    tbl[15] = '{1, 0, 10'h000, 0, 0, 0, 0, 0, 1,  1, 4'd0, 10'h000, 0};

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].rst, tbl[i].gojam, tbl[i].ruptin, tbl[i].instb, tbl[i].inhint,
            tbl[i].ovf, tbl[i].extc, tbl[i].rrpa, tbl[i].resume);
      step();
      chk_all($sformatf("vec%0d", i), int'(tbl[i].e_ruptor), int'(tbl[i].e_rptad),
              int'(tbl[i].e_pend), int'(tbl[i].e_iip));
    end

    // Three pending sources served one at a time in priority order.
    cyc(10'h224, 0, 0, 0); chk_all("multi.cap", 1, 0, 'h224, 0);
    cyc(10'h000, 1, 0, 0); chk_all("multi.g1", 0, 3, 'h224, 0);
    cyc(10'h000, 0, 1, 0); chk_all("multi.a1", 1, 3, 'h220, 1);
    cyc(10'h000, 0, 0, 1); chk_all("multi.r1", 1, 0, 'h220, 0);
    cyc(10'h000, 1, 0, 0); chk_all("multi.g2", 0, 6, 'h220, 0);
    cyc(10'h000, 0, 1, 0); chk_all("multi.a2", 1, 6, 'h200, 1);
    cyc(10'h000, 0, 0, 1);
    cyc(10'h000, 1, 0, 0); chk_all("multi.g3", 0, 10, 'h200, 0);
    cyc(10'h000, 0, 1, 0); chk_all("multi.a3", 1, 10, 'h000, 1);
    cyc(10'h000, 0, 0, 1); chk_all("multi.r3", 1, 0, 'h000, 0);

    // Higher-priority arrival while a request is outstanding does not retarget it.
    cyc(10'h040, 0, 0, 0);
    cyc(10'h040, 1, 0, 0); chk_all("frz.g", 0, 7, 'h040, 0);
    cyc(10'h041, 0, 0, 0); chk_all("frz.hi", 0, 7, 'h041, 0);
    cyc(10'h000, 0, 1, 0); chk_all("frz.a", 1, 7, 'h001, 1);
    cyc(10'h000, 0, 0, 1);
    cyc(10'h000, 1, 0, 0); chk_all("frz.g2", 0, 1, 'h001, 0);
    cyc(10'h000, 0, 1, 0);
    cyc(10'h000, 0, 0, 1); chk_all("frz.end", 1, 0, 'h000, 0);

    // New edge on the granted source in the acknowledge cycle keeps it pending.
    cyc(10'h004, 0, 0, 0);
    cyc(10'h000, 1, 0, 0); chk_all("sim.g", 0, 3, 'h004, 0);
    cyc(10'h004, 0, 1, 0); chk_all("sim.a", 1, 3, 'h004, 1);
    cyc(10'h000, 1, 0, 1); chk_all("sim.r", 1, 0, 'h004, 0);
    cyc(10'h000, 1, 0, 0); chk_all("sim.g2", 0, 3, 'h004, 0);
    cyc(10'h000, 0, 1, 0);
    cyc(10'h000, 0, 0, 1); chk_all("sim.end", 1, 0, 'h000, 0);

    // Line held high across reset release, then GOJAM during service.
    drive(1'b0, 1'b0, 10'h002, 0, 0, 0, 0, 0, 0); step();
    chk_all("rel.rst", 1, 0, 'h000, 0);
    cyc(10'h002, 0, 0, 0); chk_all("rel.first", 1, 0, 'h002, 0);
    cyc(10'h002, 1, 0, 0); chk_all("rel.g", 0, 2, 'h002, 0);
    cyc(10'h000, 0, 1, 0); chk_all("rel.a", 1, 2, 'h000, 1);
    cyc(10'h010, 0, 0, 0); chk_all("rel.p", 1, 2, 'h010, 1);
    drive(1'b1, 1'b1, 10'h000, 0, 0, 0, 0, 0, 0); step();
    chk_all("gojam", 1, 0, 'h000, 0);

    // Random traffic against the reference model.
    for (int n = 0; n < 4000; n++) begin
      logic [NSRC-1:0] tog;
      for (int b = 0; b < NSRC; b++) tog[b] = ($urandom_range(0, 7) == 0);
      drive($urandom_range(0, 299) != 0, $urandom_range(0, 149) == 0, RUPTIN ^ tog,
            $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
      step();
      chk_all($sformatf("rnd%0d", n), int'(!m_req), m_src + 1, int'(m_pend), int'(m_svc));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/rupt_priority_ctrl.md
Name: rupt_priority_ctrl

Overview:
- Priority-interrupt (rupt) controller that sits between the rupt request sources and the control-pulse sequencer, alongside the bank/rupt logic module.
- Captures rupt request edges, holds them pending, and selects the highest-priority pending request at an instruction boundary when rupts are allowed.
- Hands the selected vector index to the sequencer through a request/acknowledge handshake and tracks rupt-in-progress until RESUME.

Parameters:
NSRC, 10, number of rupt sources; bit 0 is highest priority (T6RUPT … HANDRUPT order)
ADW, 4, width of vector index output; must satisfy 2**ADW > NSRC

Ports:
CLOCK  in  1  system clock; all state updates on rising edge
rst  in  1  reset, synchronous, active-low
GOJAM  in  1  synchronous clear, same effect as reset
RUPTIN  in  NSRC  rupt request lines (level); a 0->1 transition sets pending
INHINT  in  1  rupts inhibited (level)
OVF  in  1  accumulator overflow present; blocks grant
EXTC  in  1  extracode in progress; blocks grant
INSTB  in  1  one-cycle instruction-boundary strobe; grants evaluated only here
RRPA  in  1  sequencer reads rupt vector (acknowledge)
RESUME  in  1  end of rupt service
RUPTOR_  out  1  rupt request to sequencer, active-low
RPTAD  out  ADW  vector index, 1-based (source i -> i+1); 0 = none
PEND  out  NSRC  pending request bits
IIP  out  1  rupt in progress

Behaviour:
- Reset or GOJAM=1 on a clock edge: state IDLE, PEND=0, previous-sample register=0, RPTAD=0, RUPTOR_=1, IIP=0. Because the previous-sample register is 0, a line held high at reset release registers as an edge on the first active cycle.
- Edge capture runs every cycle in every state. PEND[i] is set when RUPTIN[i]=1 and prev[i]=0. prev updates every cycle.
- Grant enable: EN = INSTB & ~INHINT & ~OVF & ~EXTC & ~IIP & (PEND != 0).
- FSM states: IDLE, REQ, SERVICE.
- IDLE:
  - If EN in cycle n, select the lowest-index set PEND bit, using PEND as registered before cycle n's captures.
  - At n+1: RPTAD = index+1, RUPTOR_=0, state REQ.
  - If EN=0, stay in IDLE with RPTAD=0.
- REQ:
  - RPTAD is frozen. Higher-priority requests arriving now only set PEND; they do not change RPTAD.
  - On RRPA=1 in cycle m, at m+1: PEND[index] is cleared, RUPTOR_=1, IIP=1, state SERVICE. RPTAD holds until leaving SERVICE.
  - INSTB, INHINT, OVF and EXTC are ignored while in REQ; the request stays asserted until RRPA.
- SERVICE:
  - On RESUME=1, next cycle: IIP=0, RPTAD=0, state IDLE.
  - A grant is possible at the first INSTB after IIP drops. It is not possible in the same cycle as RESUME, since IIP is still 1 then.
- Simultaneous events:
  - Edge on the granted source in the same cycle as RRPA: set wins, and PEND[index] stays 1.
  - RRPA in IDLE or SERVICE is ignored. RESUME in IDLE or REQ is ignored.
  - GOJAM has priority over all other inputs. A GOJAM during REQ or SERVICE aborts immediately to the reset values.
- Multiple pending bits: only one is granted per service; the remaining bits stay pending.
- No counters wrap; RPTAD never exceeds NSRC.

Test Plan:
- Reset with RUPTIN=0, pulse RUPTIN[3], then INSTB -> PEND=0x008; one cycle after INSTB RUPTOR_=0 and RPTAD=4. RRPA -> next cycle PEND=0, IIP=1, RUPTOR_=1. RESUME -> next cycle IIP=0, RPTAD=0.
- Set PEND bits 2, 5 and 9 together, then INSTB -> RPTAD=3. After RRPA and RESUME, next INSTB -> RPTAD=6, then RPTAD=10 on the third service. PEND goes 0x224 -> 0x220 -> 0x200 -> 0.
- With PEND[4]=1: INSTB while INHINT=1 -> no grant. INSTB while OVF=1 -> no grant. INSTB while EXTC=1 -> no grant. INSTB with all three 0 -> RPTAD=5.
- In REQ with RPTAD=7, raise RUPTIN[0] -> RPTAD stays 7 and PEND[0]=1. After RRPA and RESUME, next INSTB -> RPTAD=1.
- In REQ for source 2, assert RRPA in the same cycle as a new RUPTIN[2] edge -> PEND[2] remains 1 and IIP=1.
- Hold RUPTIN[1]=1 across reset release -> PEND[1]=1 on the first active cycle. Assert GOJAM during SERVICE -> next cycle IIP=0, PEND=0, RUPTOR_=1, RPTAD=0.
